// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data widths, the NOP encoding, defaults for the
// fetch stage parameters and the fetch-queue entry layout.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // Only a depth of 2 is supported by fetch_queue.
    localparam int                DEFAULT_FQ_DEPTH = 2;
    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
        logic               misalign;
    } fq_entry_t;

    // Force a byte address onto a word boundary.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry fetch FIFO between instruction memory and decode. The clear input
// empties the queue in one cycle and wins over any push/pop in that cycle.
// Entry payload is not reset; only pointers and the occupancy count are.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FQ_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               push,
    input  logic               pop,
    input  logic [ADDR_W-1:0]  push_pc,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic               push_misalign,
    output logic [1:0]         count,
    output logic               full,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [INSTR_W-1:0] head_instr,
    output logic               head_misalign
);

    localparam logic [1:0] DEPTH_L = 2'(DEPTH);

    fq_entry_t entries [2];
    logic      wr_ptr;
    logic      rd_ptr;

    assign full          = (count == DEPTH_L);
    assign head_pc       = entries[rd_ptr].pc;
    assign head_instr    = entries[rd_ptr].instr;
    assign head_misalign = entries[rd_ptr].misalign;

    // Pointer and occupancy bookkeeping; reset and clear both empty the queue.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage: write the tail slot on every push.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr] <= '{pc: push_pc, instr: push_instr, misalign: push_misalign};
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory
// combinationally and feeds a 2-entry queue towards decode. Redirects flush
// the queue and reload the PC; reset overrides everything.
// Optional feature macro: IF_ALIGN_CHECK_EN -- when defined, a redirect to a
// non-word-aligned target tags the next fetched entry with if_misalign.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          FQ_DEPTH = DEFAULT_FQ_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        if_misalign
);

    logic [ADDR_W-1:0]  pc_reg;
    logic [ADDR_W-1:0]  hold_pc;
    logic [1:0]         count;
    logic               full;
    logic               push;
    logic               pop;
    logic               push_misalign;
    logic [ADDR_W-1:0]  head_pc;
    logic [INSTR_W-1:0] head_instr;
    logic               head_misalign;
    logic               head_present;

    assign imem_addr    = pc_reg;
    assign head_present = (count != 2'd0);

    // Nothing is offered to decode while a redirect or reset is in flight.
    assign if_valid = head_present && !redirect_valid && !rst;
    assign pop      = if_valid && if_ready;
    assign push     = fetch_en && !redirect_valid && !rst && (!full || pop);

    assign if_instr    = if_valid ? head_instr : NOP_INSTR;
    assign if_pc       = head_present ? head_pc : hold_pc;
    assign if_pc_plus4 = if_pc + 32'd4;
    assign if_misalign = if_valid && head_misalign;

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk           (clk),
        .rst           (rst),
        .clear         (redirect_valid),
        .push          (push),
        .pop           (pop),
        .push_pc       (pc_reg),
        .push_instr    (imem_data),
        .push_misalign (push_misalign),
        .count         (count),
        .full          (full),
        .head_pc       (head_pc),
        .head_instr    (head_instr),
        .head_misalign (head_misalign)
    );

    // PC update: reset, then redirect, then sequential advance on each push.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg <= align_word(RESET_PC);
        end else if (redirect_valid) begin
            pc_reg <= align_word(redirect_pc);
        end else if (push) begin
            pc_reg <= pc_reg + 32'd4;
        end
    end

    // Remember the most recent head address so if_pc stays stable when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_pc <= align_word(RESET_PC);
        end else if (head_present) begin
            hold_pc <= head_pc;
        end
    end

`ifdef IF_ALIGN_CHECK_EN
    logic misalign_pending;

    assign push_misalign = misalign_pending;

    // Track a misaligned redirect until the first entry fetched after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_pending <= 1'b0;
        end else if (redirect_valid) begin
            misalign_pending <= (redirect_pc[1:0] != 2'b00);
        end else if (push) begin
            misalign_pending <= 1'b0;
        end
    end
`else
    logic unused_redirect_low;

    assign push_misalign       = 1'b0;
    assign unused_redirect_low = ^redirect_pc[1:0];
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch. Directed stimulus pushes hand-computed
// expected transfers into a scoreboard; a negedge monitor pops and compares
// every accepted instruction. Spot checks cover reset, stall, redirect, wrap,
// misalign tagging and reset-over-redirect.
module tb_instr_fetch;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] plus4;
        logic        mis;
    } exp_t;

`ifdef IF_ALIGN_CHECK_EN
    localparam logic ALIGN_EN = 1'b1;
`else
    localparam logic ALIGN_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        if_misalign;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    instr_fetch #(
        .RESET_PC (32'h0000_0000),
        .FQ_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .if_misalign    (if_misalign)
    );

    // Instruction memory: word i holds i + 0x100.
    assign imem_data = (imem_addr >> 2) + 32'h100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic fe, input logic rdy,
                                 input logic rv, input logic [31:0] rpc);
        rst            = r;
        fetch_en       = fe;
        if_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectEntry(input logic [31:0] pc, input logic [31:0] instr,
                               input logic [31:0] plus4, input logic mis);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        e.plus4 = plus4;
        e.mis   = mis;
        sb.push_back(e);
    endtask

    // Monitor: every accepted instruction must match the scoreboard head.
    always @(negedge clk) begin
        if (if_valid && if_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_transfer: got pc %h expected no transfer", if_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("xfer_pc", if_pc, e.pc);
                checkOutput("xfer_instr", if_instr, e.instr);
                checkOutput("xfer_pc_plus4", if_pc_plus4, e.plus4);
                checkOutput("xfer_misalign", {31'd0, if_misalign}, {31'd0, e.mis});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset held over two edges.
        applyStimulus(1, 0, 0, 0, 32'h0);
        tick();
        tick();
        checkOutput("rst_if_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("rst_if_instr", if_instr, 32'h0);
        checkOutput("rst_if_misalign", {31'd0, if_misalign}, 32'd0);
        checkOutput("rst_imem_addr", imem_addr, 32'h0);

        // Streaming after reset release: 0,4,8 one per cycle.
        expectEntry(32'h0, 32'h100, 32'h4, 1'b0);
        expectEntry(32'h4, 32'h101, 32'h8, 1'b0);
        expectEntry(32'h8, 32'h102, 32'hC, 1'b0);
        applyStimulus(0, 1, 1, 0, 32'h0);
        checkOutput("post_rst_if_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("post_rst_imem_addr", imem_addr, 32'h0);
        tick();
        applyStimulus(0, 1, 1, 0, 32'h0);
        checkOutput("first_if_valid", {31'd0, if_valid}, 32'd1);
        tick();
        applyStimulus(0, 1, 1, 0, 32'h0);
        tick();
        applyStimulus(0, 0, 1, 0, 32'h0);
        tick();
        applyStimulus(0, 0, 1, 0, 32'h0);
        checkOutput("empty_if_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("empty_imem_addr", imem_addr, 32'hC);
        checkOutput("empty_if_instr", if_instr, 32'h0);
        checkOutput("empty_if_pc_hold", if_pc, 32'h8);
        checkOutput("empty_if_pc_plus4_hold", if_pc_plus4, 32'hC);
        tick();

        // Stall with if_ready low: queue fills to 2, PC sticks at 8.
        applyStimulus(0, 1, 1, 1, 32'h0);
        checkOutput("redir0_if_valid", {31'd0, if_valid}, 32'd0);
        tick();
        expectEntry(32'h0, 32'h100, 32'h4, 1'b0);
        expectEntry(32'h4, 32'h101, 32'h8, 1'b0);
        expectEntry(32'h8, 32'h102, 32'hC, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 0, 0, 32'h0);
            tick();
        end
        applyStimulus(0, 1, 1, 0, 32'h0);
        checkOutput("stall_imem_addr", imem_addr, 32'h8);
        checkOutput("stall_if_pc", if_pc, 32'h0);
        checkOutput("stall_if_valid", {31'd0, if_valid}, 32'd1);
        tick();
        applyStimulus(0, 0, 1, 0, 32'h0);
        tick();
        tick();
        applyStimulus(0, 0, 1, 0, 32'h0);
        checkOutput("drain_if_valid", {31'd0, if_valid}, 32'd0);
        tick();

        // Redirect to 0x40 with a full queue and decode ready.
        applyStimulus(0, 1, 0, 0, 32'h0);
        tick();
        tick();
        applyStimulus(0, 1, 1, 1, 32'h40);
        checkOutput("redir_if_valid", {31'd0, if_valid}, 32'd0);
        tick();
        expectEntry(32'h40, 32'h110, 32'h44, 1'b0);
        applyStimulus(0, 1, 1, 0, 32'h0);
        tick();
        applyStimulus(0, 0, 1, 0, 32'h0);
        checkOutput("redir_head_valid", {31'd0, if_valid}, 32'd1);
        checkOutput("redir_head_pc", if_pc, 32'h40);
        tick();
        applyStimulus(0, 0, 1, 0, 32'h0);
        checkOutput("redir_drain_valid", {31'd0, if_valid}, 32'd0);
        tick();

        // Wrap from the top of the address space.
        expectEntry(32'hFFFF_FFFC, 32'h4000_00FF, 32'h0, 1'b0);
        expectEntry(32'h0, 32'h100, 32'h4, 1'b0);
        applyStimulus(0, 1, 1, 1, 32'hFFFF_FFFC);
        tick();
        applyStimulus(0, 1, 1, 0, 32'h0);
        tick();
        applyStimulus(0, 1, 1, 0, 32'h0);
        checkOutput("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        checkOutput("wrap_if_pc_plus4", if_pc_plus4, 32'h0);
        tick();
        applyStimulus(0, 0, 1, 0, 32'h0);
        checkOutput("wrapped_if_pc", if_pc, 32'h0);
        checkOutput("wrapped_if_pc_plus4", if_pc_plus4, 32'h4);
        tick();
        applyStimulus(0, 0, 1, 0, 32'h0);
        tick();

        // Misaligned redirect to 0x22 tags only the first entry.
        expectEntry(32'h20, 32'h108, 32'h24, ALIGN_EN);
        expectEntry(32'h24, 32'h109, 32'h28, 1'b0);
        applyStimulus(0, 1, 1, 1, 32'h22);
        tick();
        applyStimulus(0, 1, 1, 0, 32'h0);
        tick();
        applyStimulus(0, 1, 1, 0, 32'h0);
        checkOutput("mis_if_pc", if_pc, 32'h20);
        checkOutput("mis_if_misalign", {31'd0, if_misalign}, {31'd0, ALIGN_EN});
        tick();
        applyStimulus(0, 0, 1, 0, 32'h0);
        checkOutput("mis_next_misalign", {31'd0, if_misalign}, 32'd0);
        tick();
        applyStimulus(0, 0, 1, 0, 32'h0);
        tick();

        // A later aligned redirect cancels a pending misalign.
        expectEntry(32'h30, 32'h10C, 32'h34, 1'b0);
        applyStimulus(0, 0, 1, 1, 32'h23);
        tick();
        applyStimulus(0, 0, 1, 1, 32'h30);
        tick();
        applyStimulus(0, 1, 1, 0, 32'h0);
        tick();
        applyStimulus(0, 0, 1, 0, 32'h0);
        checkOutput("realign_misalign", {31'd0, if_misalign}, 32'd0);
        tick();
        applyStimulus(0, 0, 1, 0, 32'h0);
        tick();

        // Reset with a full queue and a concurrent redirect.
        applyStimulus(0, 1, 0, 0, 32'h0);
        tick();
        tick();
        applyStimulus(1, 1, 1, 1, 32'h80);
        checkOutput("rst_redir_if_valid", {31'd0, if_valid}, 32'd0);
        tick();
        applyStimulus(0, 0, 1, 0, 32'h0);
        checkOutput("after_rst_if_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("after_rst_imem_addr", imem_addr, 32'h0);
        checkOutput("after_rst_if_instr", if_instr, 32'h0);
        checkOutput("after_rst_if_misalign", {31'd0, if_misalign}, 32'd0);
        tick();
        applyStimulus(0, 0, 1, 0, 32'h0);
        checkOutput("after_rst_still_empty", {31'd0, if_valid}, 32'd0);
        tick();

        checkOutput("scoreboard_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded at reset.
REQ-002 Parameter FQ_DEPTH, default 2, SHALL be the fetch-queue depth; only the value 2 is supported.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 fetch_en  input  1  SHALL gate fetching; 0 = hold PC, no push.
REQ-006 imem_addr  output  32  SHALL be the byte address to instruction memory; memory returns the word at imem_addr[31:2] combinationally, same cycle.
REQ-007 imem_data  input  32  SHALL be the instruction word for imem_addr.
REQ-008 redirect_valid  input  1  SHALL request a PC redirect (branch/jump/exception from later stage).
REQ-009 redirect_pc  input  32  SHALL be the redirect target.
REQ-010 if_valid  output  1  SHALL flag a valid instruction at queue head.
REQ-011 if_ready  input  1  SHALL be decode acceptance; transfer when if_valid && if_ready.
REQ-012 if_instr / if_pc / if_pc_plus4  output  32 each  SHALL be head instruction, its address, address+4.
REQ-013 if_misalign  output  1  SHALL flag head entry fetched after a misaligned redirect (see Configuration).

Function
REQ-014 imem_addr SHALL equal pc_reg combinationally; pc_reg[1:0] SHALL always be 2'b00.
REQ-015 Push SHALL occur when fetch_en && !redirect_valid && (count<2 || pop); push writes {pc_reg, imem_data, flag} at tail and pc_reg <= pc_reg+4.
REQ-016 Pop SHALL be if_valid && if_ready; head advances one entry.
REQ-017 Simultaneous push and pop at count 2 or 1 SHALL keep count unchanged; at count 0 push only (no bypass: fetch-to-if_valid latency 1 cycle).
REQ-018 if_valid SHALL be (count!=0) && !redirect_valid.
REQ-019 Redirect SHALL take priority over push and pop: queue cleared (count<=0), pc_reg <= {redirect_pc[31:2],2'b00}, entry shown that cycle discarded and not counted as transferred.
REQ-020 fetch_en=0 SHALL hold pc_reg and stop pushes; pops continue; redirect still applies.
REQ-021 PC SHALL wrap modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000; if_pc_plus4 wraps identically.
REQ-022 When if_valid=0, if_instr SHALL read 32'h0000_0000 (NOP) and if_pc/if_pc_plus4 the last head values.

Reset
REQ-023 On rst=1 at a clock edge: pc_reg<=RESET_PC, count<=0, queue pointers<=0, misalign flag<=0; rst overrides redirect and fetch_en.
REQ-024 During and the cycle after reset: if_valid=0, if_instr=0, if_misalign=0, imem_addr=RESET_PC.
REQ-025 Reset mid-operation SHALL discard all queued entries with no transfer.

Configuration
REQ-026 Macro IF_ALIGN_CHECK_EN defined: redirect_pc[1:0]!=0 SHALL set a pending flag; next pushed entry carries if_misalign=1 and clears the flag; a new aligned redirect clears a pending flag.
REQ-027 Macro undefined: low bits silently cleared, if_misalign constant 0, no flag storage.

Structure
REQ-028 Shared package cpu_pkg SHALL hold INSTR_W=32, ADDR_W=32, NOP_INSTR=32'h0000_0000, FQ_DEPTH default, RESET_PC default.
REQ-029 Queue SHALL be sub-module fetch_queue (2-entry FIFO, count 0..2, with clear input); PC logic stays in instr_fetch.

Verification
REQ-030 Reset, RESET_PC=0, imem[i]=i+32'h100, if_ready=1 -> if_valid first high cycle 1 after reset release; if_pc 0,4,8 with if_instr 0x100,0x101,0x102 one per cycle.
REQ-031 if_ready=0 for 5 cycles -> count saturates at 2, pc_reg=8, imem_addr holds 8; release -> in-order 0,4,8 no loss/duplication.
REQ-032 Redirect to 0x40 while count=2 and if_ready=1 -> same cycle if_valid=0; next cycle if_pc=0x40; older entries never transferred.
REQ-033 Redirect to 32'hFFFF_FFFC -> if_pc FFFF_FFFC then 0x0, if_pc_plus4 0x0 then 0x4.
REQ-034 IF_ALIGN_CHECK_EN defined, redirect_pc=0x22 -> if_pc=0x20 with if_misalign=1, next entry 0x24 if_misalign=0; undefined -> if_misalign always 0.
REQ-035 rst asserted with count=2 and redirect_valid=1 -> next cycle count=0, pc=RESET_PC, if_valid=0.
